// File: rtl/monolith_pkg.sv
// Shared types and constants for the monolith engine front end.
package monolith_pkg;

  localparam bit [30:0] MONOLITH_P = 31'h7FFFFFFF;

  typedef bit [30:0] felt_t;

  typedef enum logic [2:0] {
    StIdle,
    StBeat2,
    StDrain,
    StRun,
    StSend
  } drv_state_t;

endpackage

// File: rtl/monolith_mod_reduce.sv
// Combinational reduction of a 32-bit word into the field modulo p = 2^31-1.
module monolith_mod_reduce
  import monolith_pkg::*;
(
  input  logic [31:0] i_x,
  output felt_t       o_y
);

  logic [31:0] w_sum;

  // 2^31 == 1 (mod p), so the top bit folds back in as +1.
  assign w_sum = {1'b0, i_x[30:0]} + {31'b0, i_x[31]};

  always_comb begin
    if (w_sum >= {1'b0, MONOLITH_P}) begin
      o_y = w_sum[30:0] - MONOLITH_P;
    end else begin
      o_y = w_sum[30:0];
    end
  end

endmodule

// File: rtl/monolith_axis_driver.sv
// AXI-Stream front end for the monolith hash/compress engine.
// Optional watchdog on RUN enabled by defining MONOLITH_DRV_WATCHDOG_EN.
module monolith_axis_driver
  import monolith_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [30:0] eng_in1,
  output logic [30:0] eng_in2,
  output logic        eng_flag,
  output logic        eng_go,
  input  logic [30:0] eng_out,
  input  logic        eng_valid,
  output logic        busy,
  output logic        proto_err
);

  drv_state_t r_state;
  felt_t      r_eng_in1;
  felt_t      r_eng_in2;
  logic       r_eng_flag;
  logic       r_eng_go;
  felt_t      r_result;
  logic       r_m_tvalid;
  logic       r_proto_err;
  felt_t      w_red;
  logic       w_accept;

  monolith_mod_reduce u_reduce (
    .i_x (s_axis_tdata),
    .o_y (w_red)
  );

  assign s_axis_tready = ~reset & ((r_state == StIdle) | (r_state == StBeat2) |
                                   (r_state == StDrain));
  assign w_accept      = s_axis_tvalid & s_axis_tready;

`ifdef MONOLITH_DRV_WATCHDOG_EN
  logic        r_tuser;
  logic [31:0] r_wd_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_eng_in1   <= '0;
      r_eng_in2   <= '0;
      r_eng_flag  <= 1'b0;
      r_eng_go    <= 1'b0;
      r_result    <= '0;
      r_m_tvalid  <= 1'b0;
      r_proto_err <= 1'b0;
`ifdef MONOLITH_DRV_WATCHDOG_EN
      r_tuser     <= 1'b0;
      r_wd_cnt    <= '0;
`endif
    end else begin
`ifdef MONOLITH_DRV_WATCHDOG_EN
      // Held at zero outside RUN, which is the same as clearing on entry.
      if (r_state != StRun) r_wd_cnt <= '0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_eng_in1 <= w_red;
            if (s_axis_tlast) begin
              r_eng_in2  <= '0;
              r_eng_flag <= 1'b0;
              r_eng_go   <= 1'b1;
              r_state    <= StRun;
            end else begin
              r_state <= StBeat2;
            end
          end
        end
        StBeat2: begin
          if (w_accept) begin
            r_eng_in2  <= w_red;
            r_eng_flag <= 1'b1;
            if (s_axis_tlast) begin
              r_eng_go <= 1'b1;
              r_state  <= StRun;
            end else begin
              r_proto_err <= 1'b1;
              r_state     <= StDrain;
            end
          end
        end
        StDrain: begin
          if (w_accept && s_axis_tlast) begin
            r_eng_go <= 1'b1;
            r_state  <= StRun;
          end
        end
        StRun: begin
          if (eng_valid) begin
            r_result   <= eng_out;
            r_eng_go   <= 1'b0;
            r_m_tvalid <= 1'b1;
            r_state    <= StSend;
`ifdef MONOLITH_DRV_WATCHDOG_EN
            r_tuser    <= 1'b0;
          end else if (r_wd_cnt == TIMEOUT_CYCLES - 1) begin
            r_result   <= '0;
            r_tuser    <= 1'b1;
            r_eng_go   <= 1'b0;
            r_m_tvalid <= 1'b1;
            r_state    <= StSend;
          end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
`endif
          end
        end
        StSend: begin
          if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef MONOLITH_DRV_WATCHDOG_EN
  assign m_axis_tuser = r_tuser;
`else
  assign m_axis_tuser = 1'b0;
`endif

  assign m_axis_tdata  = {1'b0, r_result};
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = 1'b1;
  assign eng_in1       = r_eng_in1;
  assign eng_in2       = r_eng_in2;
  assign eng_flag      = r_eng_flag;
  assign eng_go        = r_eng_go;
  assign busy          = (r_state != StIdle);
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_monolith_axis_driver.sv
// Directed plus randomized bench for monolith_axis_driver with a latency-driven engine model.
module tb_monolith_axis_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [30:0] eng_in1;
  logic [30:0] eng_in2;
  logic        eng_flag;
  logic        eng_go;
  logic [30:0] eng_out;
  logic        eng_valid = 1'b0;
  logic        busy;
  logic        proto_err;

  int          errors = 0;
  int          checks = 0;

  // Engine model: raises valid L cycles after go, drops it when go falls.
  int          eng_lat = 1;
  logic        eng_mute = 1'b0;
  logic [30:0] eng_resp = '0;
  int          gcnt = 0;

  monolith_axis_driver #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .eng_in1       (eng_in1),
    .eng_in2       (eng_in2),
    .eng_flag      (eng_flag),
    .eng_go        (eng_go),
    .eng_out       (eng_out),
    .eng_valid     (eng_valid),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  assign eng_out = eng_resp;

  always @(posedge clk) begin
    if (!eng_go || eng_mute) begin
      gcnt      <= 0;
      eng_valid <= 1'b0;
    end else begin
      gcnt      <= gcnt + 1;
      eng_valid <= (gcnt >= eng_lat - 1);
    end
  end

  function automatic logic [30:0] modp(input logic [31:0] x);
    logic [63:0] v;
    v = {32'b0, x} % 64'd2147483647;
    return v[30:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_beat(input logic [31:0] d, input logic last, output int waited);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    waited = 0;
    while (!s_axis_tready && waited < 100) begin
      tick();
      waited++;
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Called right after the last beat's accepting edge.
  task automatic wait_res(input string tag, input int lat, input logic [30:0] resp);
    int n;
    n = 0;
    while (!m_axis_tvalid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, lat + 1);
    chk({tag, "_tvalid"}, {31'b0, m_axis_tvalid}, 32'd1);
    chk({tag, "_tdata"}, m_axis_tdata, {1'b0, resp});
    chk({tag, "_tlast"}, {31'b0, m_axis_tlast}, 32'd1);
    chk({tag, "_tuser"}, {31'b0, m_axis_tuser}, 32'd0);
    chk({tag, "_go_low"}, {31'b0, eng_go}, 32'd0);
    chk({tag, "_s_ready_low"}, {31'b0, s_axis_tready}, 32'd0);
  endtask

  task automatic handshake(input string tag);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    chk({tag, "_tvalid_drop"}, {31'b0, m_axis_tvalid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic xact(input string tag, input int nb, input logic [31:0] b0,
                      input logic [31:0] b1, input int lat, input logic [30:0] resp);
    int w;
    eng_lat  = lat;
    eng_resp = resp;
    if (nb == 1) begin
      put_beat(b0, 1'b1, w);
      chk({tag, "_in2"}, {1'b0, eng_in2}, 32'd0);
      chk({tag, "_flag"}, {31'b0, eng_flag}, 32'd0);
    end else begin
      put_beat(b0, 1'b0, w);
      put_beat(b1, 1'b1, w);
      chk({tag, "_in2"}, {1'b0, eng_in2}, {1'b0, modp(b1)});
      chk({tag, "_flag"}, {31'b0, eng_flag}, 32'd1);
    end
    chk({tag, "_in1"}, {1'b0, eng_in1}, {1'b0, modp(b0)});
    chk({tag, "_go"}, {31'b0, eng_go}, 32'd1);
    wait_res(tag, lat, resp);
    handshake(tag);
  endtask

  initial begin
    int          w;
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] held;

    // Reset state
    tick();
    tick();
    chk("rst_s_ready", {31'b0, s_axis_tready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_go", {31'b0, eng_go}, 32'd0);
    chk("rst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("rst_m_tdata", m_axis_tdata, 32'd0);
    chk("rst_tuser", {31'b0, m_axis_tuser}, 32'd0);
    chk("rst_proto_err", {31'b0, proto_err}, 32'd0);
    chk("rst_in1", {1'b0, eng_in1}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_s_ready", {31'b0, s_axis_tready}, 32'd1);

    // Hash, fixed example
    xact("hash", 1, 32'h0000_0005, 32'h0, 10, 31'h1234);

    // Compress with reduction boundaries
    xact("cmp_red", 2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3, 31'h5A5A);
    xact("cmp_top", 2, 32'h8000_0000, 32'h7FFF_FFFE, 1, 31'h7FFF_FFFF);

    // Randomized packets
    for (int i = 0; i < 8; i++) begin
      xact("rand", int'($urandom_range(1, 2)), $urandom, $urandom,
           int'($urandom_range(1, 8)), 31'($urandom));
    end

    // Backpressure then back-to-back accept
    a = $urandom;
    b = $urandom;
    eng_lat  = 4;
    eng_resp = 31'h0ABC_DEF0;
    put_beat(a, 1'b1, w);
    wait_res("bp", 4, 31'h0ABC_DEF0);
    held = m_axis_tdata;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_tdata_hold", m_axis_tdata, held);
      chk("bp_tvalid_hold", {31'b0, m_axis_tvalid}, 32'd1);
      chk("bp_s_ready", {31'b0, s_axis_tready}, 32'd0);
      chk("bp_go", {31'b0, eng_go}, 32'd0);
    end
    eng_resp      = 31'h0000_0777;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    chk("bp_hs_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("bp_next_ready", {31'b0, s_axis_tready}, 32'd1);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("bp_next_in1", {1'b0, eng_in1}, {1'b0, modp(b)});
    chk("bp_next_go", {31'b0, eng_go}, 32'd1);
    wait_res("bp_next", 4, 31'h0000_0777);
    handshake("bp_next");

    // Overlong packet
    a = $urandom;
    b = $urandom;
    eng_lat  = 2;
    eng_resp = 31'h0000_0042;
    put_beat(a, 1'b0, w);
    chk("ovl_no_err_yet", {31'b0, proto_err}, 32'd0);
    put_beat(b, 1'b0, w);
    chk("ovl_err", {31'b0, proto_err}, 32'd1);
    put_beat($urandom, 1'b0, w);
    put_beat($urandom, 1'b1, w);
    chk("ovl_in1", {1'b0, eng_in1}, {1'b0, modp(a)});
    chk("ovl_in2", {1'b0, eng_in2}, {1'b0, modp(b)});
    chk("ovl_flag", {31'b0, eng_flag}, 32'd1);
    wait_res("ovl", 2, 31'h0000_0042);
    handshake("ovl");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_axis_tvalid) n++;
    end
    chk("ovl_single_result", n, 0);
    chk("ovl_err_sticky", {31'b0, proto_err}, 32'd1);

    // Reset during RUN
    eng_mute = 1'b1;
    put_beat(32'h55, 1'b1, w);
    tick();
    tick();
    chk("rrun_go_before", {31'b0, eng_go}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rrun_go", {31'b0, eng_go}, 32'd0);
    chk("rrun_busy", {31'b0, busy}, 32'd0);
    chk("rrun_proto_err", {31'b0, proto_err}, 32'd0);
    chk("rrun_s_ready", {31'b0, s_axis_tready}, 32'd0);
    chk("rrun_in1", {1'b0, eng_in1}, 32'd0);
    reset    = 1'b0;
    eng_mute = 1'b0;
    tick();
    chk("rrun_ready_after", {31'b0, s_axis_tready}, 32'd1);
    xact("post_rst", 1, 32'hDEAD_BEEF, 32'h0, 5, 31'h1357_9BDF);

`ifdef MONOLITH_DRV_WATCHDOG_EN
    eng_mute = 1'b1;
    put_beat(32'h9, 1'b1, w);
    n = 0;
    while (eng_go && n < 100) begin
      tick();
      n++;
    end
    chk("wd_run_cycles", n, 16);
    chk("wd_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
    chk("wd_tdata", m_axis_tdata, 32'd0);
    chk("wd_tuser", {31'b0, m_axis_tuser}, 32'd1);
    handshake("wd");
    eng_mute = 1'b0;
    xact("wd_after", 1, 32'h3, 32'h0, 2, 31'h11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/monolith_axis_driver.md
# monolith_axis_driver

AXI-Stream front end that issues requests to the `monolith_top` hash/compress engine and returns its results. Each input packet is reduced modulo p = 2^31−1 and latched onto the engine's `in1`/`in2`/`hash_or_compress_flag` pins. The block holds `go` for the whole computation, captures `out` when `valid` rises, and emits the digest as a one-beat AXI-Stream packet. It is the initiator on the engine's go/valid interface, and the block that takes on the engine's outstanding AXI-Stream and mod-reduce work.

## Interface
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles spent in RUN. Used only with the watchdog macro defined.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `s_axis_tdata`  in  32  raw request word.
- `s_axis_tvalid`  in  1  request beat valid.
- `s_axis_tlast`  in  1  last beat of request packet.
- `s_axis_tready`  out  1  request beat accepted when high with tvalid.
- `m_axis_tdata`  out  32  result: {1'b0, digest[30:0]}.
- `m_axis_tvalid`  out  1  result valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  tied 1; every result is one beat.
- `m_axis_tuser`  out  1  1 = watchdog timeout, in which case tdata = 0.
- `eng_in1`  out  31  engine in1.
- `eng_in2`  out  31  engine in2.
- `eng_flag`  out  1  0 = HASH, 1 = COMPRESS.
- `eng_go`  out  1  engine go, registered.
- `eng_out`  in  31  engine out.
- `eng_valid`  in  1  engine valid.
- `busy`  out  1  state ≠ IDLE.
- `proto_err`  out  1  sticky; set on an overlong packet, cleared only by reset.

## Operation
- Reduction: s = x[30:0] + x[31] (32-bit sum). Result = s − p if s ≥ p, else s.
  - 0x7FFFFFFF → 0.
  - 0xFFFFFFFF → 1.
  - 0x80000000 → 1.
- States: IDLE, BEAT2, DRAIN, RUN, SEND.
- `s_axis_tready` = ~reset & state ∈ {IDLE, BEAT2, DRAIN}.
- IDLE, on accept:
  - eng_in1 ← red(tdata).
  - If tlast: eng_in2 ← 0, eng_flag ← 0, next state RUN.
  - Else: next state BEAT2.
- BEAT2, on accept:
  - eng_in2 ← red(tdata), eng_flag ← 1.
  - If tlast: next state RUN.
  - Else: proto_err ← 1, next state DRAIN.
- DRAIN: discard beats; accept with tlast → RUN.
- RUN:
  - eng_go = 1; eng_in1/eng_in2/eng_flag are held stable.
  - eng_valid is sampled only in RUN.
  - On eng_valid: result ← eng_out, tuser ← 0, next state SEND.
- SEND:
  - eng_go = 0, which hard-resets the engine.
  - m_axis_tvalid = 1; tdata and tuser are held until accepted.
  - On tready: next state IDLE.
- eng_go is high only in RUN, so go is low for at least two cycles between requests (SEND plus IDLE). A stale eng_valid therefore never reaches RUN.

## Timing
- Reset values:
  - state IDLE; all eng_* = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0.
  - busy = 0, proto_err = 0, s_axis_tready = 0 during reset.
- Last request beat accepted at edge N → eng_go high from cycle N+1.
- Engine asserts valid L cycles after go → m_axis_tvalid high at cycle N+2+L.
- Back-to-back: the next packet can be accepted in the cycle after the SEND handshake.
- m_axis backpressure: remain in SEND; s_axis_tready = 0 and eng_go = 0 throughout.
- Reset mid-operation, in any state: next cycle is IDLE with all outputs at reset values. A partial packet is dropped; upstream restarts on a packet boundary.
- Simultaneous eng_valid and watchdog expiry in the same cycle: eng_valid wins, tuser = 0.

## Configuration
- `MONOLITH_DRV_WATCHDOG_EN` defined:
  - A counter clears on RUN entry and increments each RUN cycle.
  - On reaching TIMEOUT_CYCLES without eng_valid: result ← 0, tuser ← 1, next state SEND (go drops).
- `MONOLITH_DRV_WATCHDOG_EN` undefined:
  - No counter; RUN waits indefinitely.
  - m_axis_tuser tied 0; TIMEOUT_CYCLES unused.

## Structure
- `monolith_pkg` holds:
  - constant `MONOLITH_P = 31'h7FFFFFFF`;
  - typedef `felt_t` (bit [30:0]);
  - enum `drv_state_t`.
- Sub-module `monolith_mod_reduce`: combinational, 32-bit in → felt_t out. It is reused wherever AXI data enters the field.

## Test plan
- Hash: one beat 0x00000005 with tlast → eng_in1 = 5, eng_in2 = 0, eng_flag = 0, eng_go rises next cycle. Model answers out = 0x1234 after 10 cycles → m_axis_tdata = 0x00001234, tlast = 1, tuser = 0 at N+12.
- Compress with reduction: beats 0x7FFFFFFF, then 0xFFFFFFFF with tlast → eng_in1 = 0, eng_in2 = 1, eng_flag = 1.
- Backpressure: m_axis_tready low 5 cycles in SEND → tdata stable, s_axis_tready = 0, eng_go = 0. Handshake on cycle 6, next packet accepted the cycle after.
- Overlong: 4 beats with tlast on beat 4 → proto_err = 1 and stays 1. in1/in2 come from beats 1–2; exactly one result is emitted.
- Reset during RUN → eng_go = 0, busy = 0, proto_err = 0 next cycle. A following hash request completes normally.
- Watchdog (macro on, TIMEOUT_CYCLES = 16): engine never asserts valid → after 16 RUN cycles, eng_go = 0 and m_axis_tdata = 0 with tuser = 1.
